// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode results each cycle, with stall, flush,
// automatic load-use bubble insertion and a saturating bubble counter.
module id_ex_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [DATA_W-1:0] id_pc_i,
   input  logic [DATA_W-1:0] id_rd1_i,
   input  logic [DATA_W-1:0] id_rd2_i,
   input  logic [DATA_W-1:0] id_imm32_i,
   input  logic [4:0]        id_rs_i,
   input  logic [4:0]        id_rt_i,
   input  logic [4:0]        id_rd_i,
   input  logic [3:0]        id_aluop_i,
   input  logic              id_alusrc_i,
   input  logic [1:0]        id_regdst_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              id_memwrite_i,
   input  logic              id_mem2reg_i,
   input  logic              id_exc_i,
   input  logic [4:0]        id_exccode_i,
   output logic              ex_valid_o,
   output logic [DATA_W-1:0] ex_pc_o,
   output logic [DATA_W-1:0] ex_rd1_o,
   output logic [DATA_W-1:0] ex_rd2_o,
   output logic [DATA_W-1:0] ex_imm32_o,
   output logic [4:0]        ex_rs_o,
   output logic [4:0]        ex_rt_o,
   output logic [4:0]        ex_rd_o,
   output logic [3:0]        ex_aluop_o,
   output logic              ex_alusrc_o,
   output logic [1:0]        ex_regdst_o,
   output logic              ex_regwrite_o,
   output logic              ex_memread_o,
   output logic              ex_memwrite_o,
   output logic              ex_mem2reg_o,
   output logic              ex_exc_o,
   output logic [4:0]        ex_exccode_o,
   output logic              lu_stall_o,
   output logic [15:0]       bubble_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm32;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [3:0]        aluop;
      logic              alusrc;
      logic [1:0]        regdst;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              mem2reg;
      logic              exc;
      logic [4:0]        exccode;
   } stage_t;

   stage_t      stage_reg, stage_next;
   logic [15:0] cnt_reg, cnt_next;
   logic        bubble_inc;
   logic        hz;

   // A load in EX whose destination feeds the instruction now in ID.
   assign hz = stage_reg.valid & stage_reg.memread & (stage_reg.rt != 5'd0) &
               ((stage_reg.rt == id_rs_i) | (stage_reg.rt == id_rt_i)) & id_valid_i;
   assign lu_stall_o = hz & ~stall_i & ~flush_i;

   always_comb begin
      stage_next = stage_reg;
      bubble_inc = 1'b0;
      if (flush_i) begin
         stage_next = '0;
         bubble_inc = 1'b1;
      end else if (stall_i) begin
         stage_next = stage_reg;
      end else if (hz) begin
         stage_next = '0;
         bubble_inc = 1'b1;
      end else if (!id_valid_i) begin
         stage_next = '0;
      end else begin
         stage_next.valid    = 1'b1;
         stage_next.pc       = id_pc_i;
         stage_next.rd1      = id_rd1_i;
         stage_next.rd2      = id_rd2_i;
         stage_next.imm32    = id_imm32_i;
         stage_next.rs       = id_rs_i;
         stage_next.rt       = id_rt_i;
         stage_next.rd       = id_rd_i;
         stage_next.aluop    = id_aluop_i;
         stage_next.alusrc   = id_alusrc_i;
         stage_next.regdst   = id_regdst_i;
         stage_next.mem2reg  = id_mem2reg_i;
         stage_next.exc      = id_exc_i;
         stage_next.exccode  = id_exccode_i;
         // A faulting instruction must not write state; PC is kept as the EPC.
         stage_next.regwrite = id_regwrite_i & ~id_exc_i;
         stage_next.memread  = id_memread_i  & ~id_exc_i;
         stage_next.memwrite = id_memwrite_i & ~id_exc_i;
      end
      cnt_next = cnt_reg;
      if (bubble_inc && (cnt_reg != 16'hFFFF)) begin
         cnt_next = cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         stage_reg <= stage_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign ex_valid_o    = stage_reg.valid;
   assign ex_pc_o       = stage_reg.pc;
   assign ex_rd1_o      = stage_reg.rd1;
   assign ex_rd2_o      = stage_reg.rd2;
   assign ex_imm32_o    = stage_reg.imm32;
   assign ex_rs_o       = stage_reg.rs;
   assign ex_rt_o       = stage_reg.rt;
   assign ex_rd_o       = stage_reg.rd;
   assign ex_aluop_o    = stage_reg.aluop;
   assign ex_alusrc_o   = stage_reg.alusrc;
   assign ex_regdst_o   = stage_reg.regdst;
   assign ex_regwrite_o = stage_reg.regwrite;
   assign ex_memread_o  = stage_reg.memread;
   assign ex_memwrite_o = stage_reg.memwrite;
   assign ex_mem2reg_o  = stage_reg.mem2reg;
   assign ex_exc_o      = stage_reg.exc;
   assign ex_exccode_o  = stage_reg.exccode;
   assign bubble_cnt_o  = cnt_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized + directed bench for id_ex_reg; a queue-based scoreboard checks every
// registered output cycle against a slot-level model of the pipeline register.
module tb_id_ex_reg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [3:0]  aluop;
      logic        alusrc;
      logic [1:0]  regdst;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        mem2reg;
      logic        exc;
      logic [4:0]  exccode;
   } slot_t;

   typedef struct {
      slot_t f;
      int    cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst, stall_i, flush_i;
   slot_t din;
   slot_t act;

   logic              ex_valid_o, ex_alusrc_o, ex_regwrite_o, ex_memread_o;
   logic              ex_memwrite_o, ex_mem2reg_o, ex_exc_o, lu_stall_o;
   logic [31:0]       ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm32_o;
   logic [4:0]        ex_rs_o, ex_rt_o, ex_rd_o, ex_exccode_o;
   logic [3:0]        ex_aluop_o;
   logic [1:0]        ex_regdst_o;
   logic [15:0]       bubble_cnt_o;

   slot_t model;
   int    model_cnt;
   exp_t  sb[$];
   int    errors = 0;
   int    checks = 0;

   always #5 clk = ~clk;

   id_ex_reg #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .id_valid_i(din.valid), .id_pc_i(din.pc), .id_rd1_i(din.rd1), .id_rd2_i(din.rd2),
      .id_imm32_i(din.imm), .id_rs_i(din.rs), .id_rt_i(din.rt), .id_rd_i(din.rd),
      .id_aluop_i(din.aluop), .id_alusrc_i(din.alusrc), .id_regdst_i(din.regdst),
      .id_regwrite_i(din.regwrite), .id_memread_i(din.memread),
      .id_memwrite_i(din.memwrite), .id_mem2reg_i(din.mem2reg),
      .id_exc_i(din.exc), .id_exccode_i(din.exccode),
      .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o),
      .ex_imm32_o(ex_imm32_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
      .ex_aluop_o(ex_aluop_o), .ex_alusrc_o(ex_alusrc_o), .ex_regdst_o(ex_regdst_o),
      .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
      .ex_memwrite_o(ex_memwrite_o), .ex_mem2reg_o(ex_mem2reg_o),
      .ex_exc_o(ex_exc_o), .ex_exccode_o(ex_exccode_o),
      .lu_stall_o(lu_stall_o), .bubble_cnt_o(bubble_cnt_o)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Monitor: the register presents a new slot after every rising edge.
   always begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         act = '{ex_valid_o, ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm32_o, ex_rs_o, ex_rt_o,
                 ex_rd_o, ex_aluop_o, ex_alusrc_o, ex_regdst_o, ex_regwrite_o,
                 ex_memread_o, ex_memwrite_o, ex_mem2reg_o, ex_exc_o, ex_exccode_o};
         checks++;
         if (act !== e.f) begin
            errors++;
            $display("FAIL ex_fields: got %h want %h", act, e.f);
         end
         checks++;
         if (bubble_cnt_o !== 16'(e.cnt)) begin
            errors++;
            $display("FAIL bubble_cnt: got %0d want %0d", bubble_cnt_o, e.cnt);
         end
      end
   end

   // One clock of stimulus, issued at a falling edge; pushes the expected next slot.
   task automatic cyc(input logic r, input logic f, input logic s, input slot_t in);
      logic hz;
      exp_t e;
      rst = r; flush_i = f; stall_i = s; din = in;
      #1;
      hz = model.valid && model.memread && model.rt != 0 &&
           (model.rt == in.rs || model.rt == in.rt) && in.valid;
      if (!r) chk("lu_stall", 32'(lu_stall_o), 32'(hz && !s && !f));
      if (r) begin
         model = '0; model_cnt = 0;
      end else if (f || (!s && hz)) begin
         model = '0;
         if (model_cnt < 65535) model_cnt++;
      end else if (!s) begin
         if (!in.valid) model = '0;
         else begin
            model = in;
            if (in.exc) begin
               model.regwrite = 1'b0; model.memread = 1'b0; model.memwrite = 1'b0;
            end
         end
      end
      e.f = model; e.cnt = model_cnt;
      sb.push_back(e);
      @(negedge clk);
   endtask

   function automatic slot_t rand_slot();
      slot_t t;
      t = slot_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      t.valid   = ($urandom_range(0, 7) != 0);
      t.rs      = 5'($urandom_range(0, 3));
      t.rt      = 5'($urandom_range(0, 3));
      t.memread = $urandom_range(0, 1) == 1;
      t.exc     = ($urandom_range(0, 7) == 0);
      return t;
   endfunction

   initial begin
      slot_t s;
      model = '0; model_cnt = 0;
      // Reset with arbitrary inputs
      cyc(1, 0, 0, rand_slot());
      cyc(1, 0, 0, rand_slot());
      chk("reset_valid", 32'(ex_valid_o), 0);
      chk("reset_pc", ex_pc_o, 0);
      chk("reset_cnt", 32'(bubble_cnt_o), 0);

      s = '0; s.valid = 1; s.pc = 32'h0000_3004; s.imm = 32'hFFFF_FFF0; s.regwrite = 1;
      cyc(0, 0, 0, s);
      chk("plain_pc", ex_pc_o, 32'h0000_3004);
      chk("plain_imm", ex_imm32_o, 32'hFFFF_FFF0);
      chk("plain_valid", 32'(ex_valid_o), 1);

      // Load-use: lw rt=8 followed by add rs=8, then the same with rt=0
      for (int k = 0; k < 2; k++) begin
         slot_t lw, add;
         lw = '0; lw.valid = 1; lw.memread = 1; lw.mem2reg = 1; lw.regwrite = 1;
         lw.rt = (k == 0) ? 5'd8 : 5'd0;
         add = '0; add.valid = 1; add.rs = lw.rt; add.rt = 5'd3; add.rd = 5'd9;
         add.regwrite = 1; add.pc = 32'h0000_3008;
         cyc(0, 0, 0, lw);
         din = add;
         #1;
         chk("lu_pair", 32'(lu_stall_o), (k == 0) ? 1 : 0);
         cyc(0, 0, 0, add);
         chk("lu_bubble_valid", 32'(ex_valid_o), (k == 0) ? 0 : 1);
         chk("lu_bubble_cnt", 32'(bubble_cnt_o), 1);
         if (k == 0) cyc(0, 0, 0, add);
         chk("lu_add_loaded", ex_pc_o, 32'h0000_3008);
      end

      // Stall for 3 cycles, then stall together with flush
      for (int k = 0; k < 3; k++) cyc(0, 0, 1, rand_slot());
      chk("stall_hold_pc", ex_pc_o, 32'h0000_3008);
      cyc(0, 1, 1, rand_slot());
      chk("stall_flush_cnt", 32'(bubble_cnt_o), 2);

      s = '0; s.valid = 1; s.exc = 1; s.exccode = 5'd10; s.regwrite = 1; s.memwrite = 1;
      s.pc = 32'h0000_3010;
      cyc(0, 0, 0, s);
      chk("exc_flag", 32'(ex_exc_o), 1);
      chk("exc_code", 32'(ex_exccode_o), 10);
      chk("exc_pc", ex_pc_o, 32'h0000_3010);
      chk("exc_regwrite", 32'(ex_regwrite_o), 0);
      chk("exc_memwrite", 32'(ex_memwrite_o), 0);

      for (int k = 0; k < 3000; k++) begin
         cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 7) == 0, rand_slot());
      end

      cyc(1, 0, 0, rand_slot());
      for (int k = 0; k < 65536; k++) cyc(0, 1, $urandom_range(0, 1) == 1, rand_slot());
      chk("sat_cnt", 32'(bubble_cnt_o), 32'h0000_FFFF);
      cyc(0, 0, 0, rand_slot());
      chk("sat_hold", 32'(bubble_cnt_o), 32'h0000_FFFF);
      cyc(1, 0, 0, rand_slot());
      chk("sat_reset", 32'(bubble_cnt_o), 0);

      for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the pipelined integer CPU. Captures decode-stage results (PC, register operands, the 32-bit extended immediate, register specifiers, control bits, exception tag) on each clock and presents them to the execute stage. Provides stall, flush and automatic load-use bubble insertion, and keeps a saturating count of inserted bubbles.

## Interface
- DATA_W, 32, width of PC, operand and immediate fields
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- stall_i  in  1  external hold; register keeps its contents
- flush_i  in  1  external kill; register loads a bubble
- id_valid_i  in  1  decode slot holds a real instruction
- id_pc_i, id_rd1_i, id_rd2_i, id_imm32_i  in  DATA_W each  PC, read data 1/2, extended immediate
- id_rs_i, id_rt_i, id_rd_i  in  5 each  register specifiers
- id_aluop_i  in  4  ALU operation; id_alusrc_i  in  1  immediate select
- id_regdst_i  in  2  write-register select
- id_regwrite_i, id_memread_i, id_memwrite_i, id_mem2reg_i  in  1 each
- id_exc_i  in  1  decode exception (e.g. reserved opcode); id_exccode_i  in  5
- ex_* outputs  out  same widths  registered copies of every id_* input, plus ex_valid_o
- lu_stall_o  out  1  combinational load-use stall request to PC and IF/ID
- bubble_cnt_o  out  16  saturating count of bubbles inserted

## Operation
- Load-use hazard: hz = ex_valid_o & ex_memread_o & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i)) & id_valid_i. lu_stall_o = hz & ~stall_i & ~flush_i.
- Per-cycle action, priority order: rst > flush_i > stall_i > hz > load.
  - rst: bubble, bubble_cnt_o = 0.
  - flush_i: bubble; counter +1.
  - stall_i: hold all fields and ex_valid_o; counter unchanged.
  - hz: bubble; counter +1; upstream holds via lu_stall_o.
  - load: every ex_* field <= matching id_* input; ex_valid_o <= id_valid_i.
- Bubble: ex_valid_o=0; all data, specifier, aluop, regdst, exccode fields 0; regwrite, memread, memwrite, mem2reg, alusrc, exc all 0.
- Exception squash on load: if id_exc_i=1, ex_regwrite_o, ex_memread_o, ex_memwrite_o forced 0; ex_exc_o=1, ex_exccode_o, ex_pc_o captured (EPC source); ex_valid_o = id_valid_i.
- Load with id_valid_i=0 is a bubble with ex_valid_o=0 but is not counted.
- Counter saturates at 16'hFFFF; no wrap.

## Timing
- Latency: 1 cycle from id_* to ex_*.
- Reset values: every ex_* output 0, ex_valid_o 0, bubble_cnt_o 0; lu_stall_o 0 in the cycle after reset (EX slot empty).
- lu_stall_o is combinational from current ex_* state and id_* inputs; it is asserted for exactly one cycle per load-use pair, since the next cycle EX holds a bubble.
- flush_i and stall_i same cycle: flush wins. flush_i and hz same cycle: one bubble, counted once, lu_stall_o=0.
- rst mid-stall or mid-hazard: reset wins, counter cleared.
- stall_i does not mask hz evaluation for later cycles; hazard resolves once the stall releases.

## Test plan
- Reset: assert rst 2 cycles with arbitrary id_* -> all ex_* = 0, ex_valid_o=0, bubble_cnt_o=0.
- Plain load: id_pc_i=32'h0000_3004, id_imm32_i=32'hFFFF_FFF0, id_regwrite_i=1, id_valid_i=1 -> next cycle ex_pc_o=32'h0000_3004, ex_imm32_o=32'hFFFF_FFF0, ex_regwrite_o=1, ex_valid_o=1.
- Load-use: EX holds lw with rt=8, ID presents add with rs=8 -> lu_stall_o=1 that cycle; next cycle ex_valid_o=0, bubble_cnt_o=1, lu_stall_o=0; following cycle add loaded. Repeat with rt=0 -> lu_stall_o=0, no bubble.
- Stall/flush priority: stall_i=1 for 3 cycles -> ex_* unchanged; stall_i=1 & flush_i=1 -> bubble, counter +1.
- Exception: id_exc_i=1, id_exccode_i=5'd10, id_regwrite_i=1, id_memwrite_i=1, id_pc_i=32'h0000_3010 -> ex_exc_o=1, ex_exccode_o=10, ex_pc_o=32'h0000_3010, ex_regwrite_o=0, ex_memwrite_o=0.
- Saturation: force 65536 flushes -> bubble_cnt_o holds 16'hFFFF; rst -> 0.
